periph_responder: RTL

- Device-side end of the core's peripheral port: consumes core commands (to_peripheral, to_peripheral_data, to_peripheral_valid) and returns responses (from_peripheral, from_peripheral_data, from_peripheral_valid).
- Buffers core-to-device words in an outbound FIFO that drains to a ready/valid stream.
- Buffers device-to-core words from an inbound ready/valid stream in an inbound FIFO that the core reads.
- Sits beside RISC_V_Core in SoC tops and benches; replaces hand-driven from_peripheral stimulus.

---
 rtl/periph_responder_pkg.sv | 22 ++
 rtl/periph_responder_fifo.sv | 64 ++++++
 rtl/periph_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/periph_responder_pkg.sv
// Shared encodings for the core <-> peripheral command/response port.
// Imported by the core side, the responder and the benches.
package periph_responder_pkg;

  localparam int CMD_W = 2;
  localparam int RSP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_READ   = 2'b10,
    CMD_STATUS = 2'b11
  } cmd_e;

  typedef enum logic [RSP_W-1:0] {
    RSP_NONE = 2'b00,
    RSP_ACK  = 2'b01,
    RSP_DATA = 2'b10,
    RSP_ERR  = 2'b11
  } rsp_e;

endpackage

// File: rtl/periph_responder_fifo.sv
// Synchronous FIFO with first-word-fall-through head; full/empty are pre-edge,
// so a push on full or a pop on empty is refused even with a same-edge partner.
module periph_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BITS   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_BITS-1:0]   count
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  // Head reads as zero when empty so stale storage never leaks out after reset.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/periph_responder.sv
// Device-side end of the core peripheral port: decodes core commands, buffers
// traffic in outbound/inbound FIFOs and returns a registered 1-cycle response.
module periph_responder
  import periph_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BITS   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  logic                  cmd_valid;
  logic                  out_push, out_full, out_empty;
  logic [CNT_BITS-1:0]   out_count;
  logic                  in_push, in_pop, in_full, in_empty;
  logic [DATA_WIDTH-1:0] in_head;
  logic [CNT_BITS-1:0]   in_count;
  logic [DATA_WIDTH-1:0] status_word;

  logic                  armed_q, armed_d;
  rsp_e                  rsp_code_q, rsp_code_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;

  // in_ready stays low through reset and rises on the first clock after release.
  assign armed_d   = 1'b1;
  assign in_ready  = armed_q && !in_full;
  assign in_push   = in_valid && in_ready;
  assign out_valid = !out_empty;
  assign cmd_valid = to_peripheral_valid && (to_peripheral != CMD_NOP);

  assign status_word = {{(DATA_WIDTH-2*CNT_BITS){1'b0}}, in_count, out_count};

  periph_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_BITS(CNT_BITS)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_push),
    .push_data (to_peripheral_data),
    .pop       (out_ready),
    .head      (out_data),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  periph_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_BITS(CNT_BITS)
  ) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_push),
    .push_data (in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_code_d  = RSP_NONE;
    rsp_data_d  = '0;
    out_push    = 1'b0;
    in_pop      = 1'b0;
    if (cmd_valid) begin
      rsp_valid_d = 1'b1;
      case (to_peripheral)
        CMD_WRITE: begin
          if (out_full) begin
            rsp_code_d = RSP_ERR;
          end else begin
            rsp_code_d = RSP_ACK;
            out_push   = 1'b1;
          end
        end
        CMD_READ: begin
          if (in_empty) begin
            rsp_code_d = RSP_ERR;
          end else begin
            rsp_code_d = RSP_DATA;
            rsp_data_d = in_head;
            in_pop     = 1'b1;
          end
        end
        CMD_STATUS: begin
          rsp_code_d = RSP_DATA;
          rsp_data_d = status_word;
        end
        default: begin
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q     <= 1'b0;
      rsp_code_q  <= RSP_NONE;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign from_peripheral       = rsp_code_q;
  assign from_peripheral_data  = rsp_data_q;
  assign from_peripheral_valid = rsp_valid_q;

endmodule
